// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register
// saturating pending-write scoreboard for out-of-order writeback.
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter int REG_NUM   = 32,
    parameter int ADDR_SIZE = 5,
    parameter int RD_PORTS  = 2,
    parameter int WR_PORTS  = 2,
    parameter int CNT_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RD_PORTS*ADDR_SIZE-1:0] rd_addr,
    output logic [RD_PORTS*XLEN-1:0]      rd_data,
    output logic [RD_PORTS-1:0]           rd_busy,
    input  logic                          iss_valid,
    input  logic [ADDR_SIZE-1:0]          iss_rd,
    output logic                          iss_stall,
    input  logic [WR_PORTS-1:0]           wb_we,
    input  logic [WR_PORTS*ADDR_SIZE-1:0] wb_rd,
    input  logic [WR_PORTS*XLEN-1:0]      wb_data,
    input  logic                          flush,
    output logic                          sb_err
);

    localparam int NIDX  = 2**ADDR_SIZE;
    localparam int HIT_W = $clog2(WR_PORTS + 1);
    localparam int CMP_W = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;

    logic [XLEN-1:0] regs_reg [NIDX];
    logic [NIDX-1:0] busy_vec;
    logic [NIDX-1:0] full_vec;
    logic [NIDX-1:0] uflow_vec;

    genvar gi;

    // Ascending port loop: the last matching (highest) port wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NIDX; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int k = 0; k < WR_PORTS; k++) begin
                if (wb_we[k] && wb_rd[k*ADDR_SIZE +: ADDR_SIZE] != '0 &&
                    int'(wb_rd[k*ADDR_SIZE +: ADDR_SIZE]) < REG_NUM) begin
                    regs_reg[wb_rd[k*ADDR_SIZE +: ADDR_SIZE]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [ADDR_SIZE-1:0] addr;
            logic [XLEN-1:0]      data;

            assign addr = rd_addr[gi*ADDR_SIZE +: ADDR_SIZE];

            always_comb begin
                data = regs_reg[addr];
                for (int k = 0; k < WR_PORTS; k++) begin
                    if (wb_we[k] && wb_rd[k*ADDR_SIZE +: ADDR_SIZE] == addr) begin
                        data = wb_data[k*XLEN +: XLEN];
                    end
                end
                if (addr == '0 || int'(addr) >= REG_NUM) begin
                    data = '0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
            assign rd_busy[gi]              = busy_vec[addr];
        end
    endgenerate

    assign iss_stall = iss_valid && (iss_rd != '0) && !flush && full_vec[iss_rd];

    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_cnt
            if (gi == 0 || gi >= REG_NUM) begin : g_none
                assign busy_vec[gi]  = 1'b0;
                assign full_vec[gi]  = 1'b0;
                assign uflow_vec[gi] = 1'b0;
            end else begin : g_live
                logic [HIT_W-1:0] hits;
                logic [CMP_W-1:0] cnt_x;
                logic [CMP_W-1:0] hits_x;
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic [CNT_W-1:0] rem;
                logic             inc;

                always_comb begin
                    hits = '0;
                    for (int k = 0; k < WR_PORTS; k++) begin
                        if (wb_we[k] && wb_rd[k*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(gi)) begin
                            hits = hits + HIT_W'(1);
                        end
                    end
                end

                // Retirements clamp at zero; an excess retirement is an underflow.
                assign cnt_x  = CMP_W'(cnt_reg);
                assign hits_x = CMP_W'(hits);
                assign rem    = (hits_x >= cnt_x) ? '0 : CNT_W'(cnt_x - hits_x);

                assign uflow_vec[gi] = hits_x > cnt_x;
                assign busy_vec[gi]  = rem != '0;
                assign full_vec[gi]  = &rem;

                // A full counter stalls its own issue, so rem + inc never wraps.
                assign inc      = iss_valid && !iss_stall && !flush && (iss_rd == ADDR_SIZE'(gi));
                assign cnt_next = flush ? '0 : rem + CNT_W'(inc);

                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (!flush && (|uflow_vec)) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run compared against a behavioural register/counter model.
module tb_regfile_scoreboard;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int ADDR_SIZE = 5;
    localparam int RD_PORTS  = 2;
    localparam int WR_PORTS  = 2;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [RD_PORTS*ADDR_SIZE-1:0] rd_addr;
    logic [RD_PORTS*XLEN-1:0]      rd_data;
    logic [RD_PORTS-1:0]           rd_busy;
    logic                          iss_valid;
    logic [ADDR_SIZE-1:0]          iss_rd;
    logic                          iss_stall;
    logic [WR_PORTS-1:0]           wb_we;
    logic [WR_PORTS*ADDR_SIZE-1:0] wb_rd;
    logic [WR_PORTS*XLEN-1:0]      wb_data;
    logic                          flush;
    logic                          sb_err;

    int checks = 0;
    int passes = 0;

    logic [XLEN-1:0] m_regs [REG_NUM];
    int              m_cnt  [REG_NUM];
    bit              m_err;

    regfile_scoreboard #(
        .XLEN(XLEN), .REG_NUM(REG_NUM), .ADDR_SIZE(ADDR_SIZE),
        .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic int wb_dst(int k);
        return int'(wb_rd[k*ADDR_SIZE +: ADDR_SIZE]);
    endfunction

    function automatic int hits_of(int r);
        int h = 0;
        if (r == 0) return 0;
        for (int k = 0; k < WR_PORTS; k++) begin
            if (wb_we[k] && wb_dst(k) == r) h++;
        end
        return h;
    endfunction

    function automatic int remaining(int r);
        int h = hits_of(r);
        return (m_cnt[r] > h) ? m_cnt[r] - h : 0;
    endfunction

    function automatic bit exp_stall();
        if (!iss_valid || iss_rd == '0 || flush) return 1'b0;
        return remaining(int'(iss_rd)) == CNT_MAX;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(int p);
        int a = int'(rd_addr[p*ADDR_SIZE +: ADDR_SIZE]);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int k = 0; k < WR_PORTS; k++) begin
            if (wb_we[k] && wb_dst(k) == a) v = wb_data[k*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic bit exp_busy(int p);
        int a = int'(rd_addr[p*ADDR_SIZE +: ADDR_SIZE]);
        return (a != 0) && (m_cnt[a] > hits_of(a));
    endfunction

    task automatic model_update();
        int h [REG_NUM];
        bit s;
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                m_regs[r] = '0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
            return;
        end
        s = exp_stall();
        for (int r = 0; r < REG_NUM; r++) h[r] = hits_of(r);
        for (int k = 0; k < WR_PORTS; k++) begin
            if (wb_we[k] && wb_dst(k) != 0) m_regs[wb_dst(k)] = wb_data[k*XLEN +: XLEN];
        end
        for (int r = 1; r < REG_NUM; r++) begin
            if (flush) begin
                m_cnt[r] = 0;
            end else begin
                if (h[r] > m_cnt[r]) m_err = 1'b1;
                m_cnt[r] = ((h[r] > m_cnt[r]) ? 0 : m_cnt[r] - h[r]) +
                           ((iss_valid && !s && int'(iss_rd) == r) ? 1 : 0);
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        wb_we = '0; wb_rd = '0; wb_data = '0; rd_addr = '0;
    endtask

    task automatic set_wb(int k, int r, logic [XLEN-1:0] d);
        wb_we[k] = 1'b1;
        wb_rd[k*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'(r);
        wb_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(int p, int a);
        rd_addr[p*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'(a);
    endtask

    task automatic issue(int r);
        iss_valid = 1'b1;
        iss_rd = ADDR_SIZE'(r);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; tick(); tick(); idle();
        set_rd(0, 5); set_rd(1, 5); #1;
        checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passes++;
        checks++; if (rd_busy !== '0) $display("FAIL reset_rd_busy: got %b want 00", rd_busy); else passes++;
        checks++; if (iss_stall !== 1'b0) $display("FAIL reset_iss_stall: got %b want 0", iss_stall); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err: got %b want 0", sb_err); else passes++;
        $display("reset: rd_data=%h rd_busy=%b iss_stall=%b sb_err=%b", rd_data, rd_busy, iss_stall, sb_err);
    endtask

    task automatic test_write_through();
        idle(); set_rd(0, 5); set_wb(0, 5, 32'hDEAD); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'hDEAD) $display("FAIL bypass_r5: got %h want 0000dead", rd_data[0 +: XLEN]); else passes++;
        tick(); idle(); set_rd(0, 5); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'hDEAD) $display("FAIL stored_r5: got %h want 0000dead", rd_data[0 +: XLEN]); else passes++;
        $display("write_through: r5=%h", rd_data[0 +: XLEN]);
    endtask

    task automatic test_collision();
        idle(); set_wb(0, 7, 32'h11); set_wb(1, 7, 32'h22); set_rd(0, 7); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'h22) $display("FAIL collide_bypass: got %h want 00000022", rd_data[0 +: XLEN]); else passes++;
        tick(); idle(); set_rd(0, 7); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'h22) $display("FAIL collide_stored: got %h want 00000022", rd_data[0 +: XLEN]); else passes++;
        set_wb(0, 0, 32'hFF); set_rd(1, 0); #1;
        checks++; if (rd_data[XLEN +: XLEN] !== '0) $display("FAIL r0_bypass: got %h want 0", rd_data[XLEN +: XLEN]); else passes++;
        tick(); idle(); set_rd(1, 0); #1;
        checks++; if (rd_data[XLEN +: XLEN] !== '0) $display("FAIL r0_stored: got %h want 0", rd_data[XLEN +: XLEN]); else passes++;
        $display("collision: r7=%h r0=%h", rd_data[0 +: XLEN], rd_data[XLEN +: XLEN]);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(3); tick();
        end
        idle(); issue(3); set_rd(0, 3); #1;
        checks++; if (iss_stall !== 1'b1) $display("FAIL sat_stall: got %b want 1", iss_stall); else passes++;
        checks++; if (rd_busy[0] !== 1'b1) $display("FAIL sat_busy: got %b want 1", rd_busy[0]); else passes++;
        tick(); idle(); issue(3); set_wb(0, 3, 32'h33); set_rd(0, 3); #1;
        checks++; if (iss_stall !== 1'b0) $display("FAIL sat_issue_with_wb: got %b want 0", iss_stall); else passes++;
        checks++; if (rd_busy[0] !== 1'b1) $display("FAIL sat_busy_with_wb: got %b want 1", rd_busy[0]); else passes++;
        tick(); idle(); issue(3); #1;
        checks++; if (iss_stall !== 1'b1) $display("FAIL sat_still_full: got %b want 1", iss_stall); else passes++;
        $display("saturation: iss_stall=%b after 3 issues + issue/wb pair", iss_stall);
        idle(); flush = 1'b1; tick(); idle();
    endtask

    task automatic test_multi_retire();
        do_reset();
        issue(4); tick(); issue(4); tick();
        idle(); set_rd(0, 4); #1;
        checks++; if (rd_busy[0] !== 1'b1) $display("FAIL r4_busy_pending: got %b want 1", rd_busy[0]); else passes++;
        set_wb(0, 4, 32'hA4); set_wb(1, 4, 32'hB4); #1;
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL r4_busy_retire: got %b want 0", rd_busy[0]); else passes++;
        checks++; if (rd_data[0 +: XLEN] !== 32'hB4) $display("FAIL r4_data: got %h want 000000b4", rd_data[0 +: XLEN]); else passes++;
        tick(); idle(); set_rd(0, 4); #1;
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL r4_busy_after: got %b want 0", rd_busy[0]); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL r4_sb_err: got %b want 0", sb_err); else passes++;
        $display("multi_retire: busy=%b sb_err=%b", rd_busy[0], sb_err);
    endtask

    task automatic test_underflow();
        do_reset();
        set_wb(0, 9, 32'h99); set_rd(0, 9); #1;
        checks++; if (sb_err !== 1'b0) $display("FAIL uf_err_early: got %b want 0", sb_err); else passes++;
        tick(); idle(); set_rd(0, 9); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'h99) $display("FAIL uf_data: got %h want 00000099", rd_data[0 +: XLEN]); else passes++;
        checks++; if (sb_err !== 1'b1) $display("FAIL uf_err_set: got %b want 1", sb_err); else passes++;
        checks++; if (rd_busy[0] !== 1'b0) $display("FAIL uf_busy: got %b want 0", rd_busy[0]); else passes++;
        tick();
        checks++; if (sb_err !== 1'b1) $display("FAIL uf_err_sticky: got %b want 1", sb_err); else passes++;
        rst = 1'b1; tick(); idle(); set_rd(0, 9); #1;
        checks++; if (sb_err !== 1'b0) $display("FAIL uf_err_cleared: got %b want 0", sb_err); else passes++;
        checks++; if (rd_data[0 +: XLEN] !== '0) $display("FAIL uf_reg_cleared: got %h want 0", rd_data[0 +: XLEN]); else passes++;
        $display("underflow: sb_err=%b after rst", sb_err);
    endtask

    task automatic test_flush();
        do_reset();
        issue(2); tick();
        for (int i = 0; i < 3; i++) begin
            issue(6); tick();
        end
        idle(); flush = 1'b1; issue(2); set_wb(0, 6, 32'h5); set_wb(1, 10, 32'hAB); #1;
        checks++; if (iss_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", iss_stall); else passes++;
        tick(); idle(); set_rd(0, 2); set_rd(1, 6); #1;
        checks++; if (rd_busy !== 2'b00) $display("FAIL flush_busy: got %b want 00", rd_busy); else passes++;
        checks++; if (rd_data[XLEN +: XLEN] !== 32'h5) $display("FAIL flush_r6: got %h want 00000005", rd_data[XLEN +: XLEN]); else passes++;
        checks++; if (sb_err !== 1'b0) $display("FAIL flush_sb_err: got %b want 0", sb_err); else passes++;
        set_rd(0, 10); #1;
        checks++; if (rd_data[0 +: XLEN] !== 32'hAB) $display("FAIL flush_r10: got %h want 000000ab", rd_data[0 +: XLEN]); else passes++;
        $display("flush: busy=%b r6=%h sb_err=%b", rd_busy, rd_data[XLEN +: XLEN], sb_err);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = ADDR_SIZE'($urandom_range(0, 7));
            for (int k = 0; k < WR_PORTS; k++) begin
                if ($urandom_range(0, 3) == 0) set_wb(k, $urandom_range(0, 7), $urandom);
            end
            for (int p = 0; p < RD_PORTS; p++) set_rd(p, $urandom_range(0, 9));
            #1;
            if (!rst) begin
                for (int p = 0; p < RD_PORTS; p++) begin
                    checks++;
                    if (rd_data[p*XLEN +: XLEN] !== exp_rd(p)) begin
                        $display("FAIL rand_rd_data[%0d] cyc %0d: got %h want %h", p, n, rd_data[p*XLEN +: XLEN], exp_rd(p)); bad++;
                    end else passes++;
                    checks++;
                    if (rd_busy[p] !== exp_busy(p)) begin
                        $display("FAIL rand_rd_busy[%0d] cyc %0d: got %b want %b", p, n, rd_busy[p], exp_busy(p)); bad++;
                    end else passes++;
                end
                checks++;
                if (iss_stall !== exp_stall()) begin
                    $display("FAIL rand_iss_stall cyc %0d: got %b want %b", n, iss_stall, exp_stall()); bad++;
                end else passes++;
            end
            checks++;
            if (sb_err !== m_err) begin
                $display("FAIL rand_sb_err cyc %0d: got %b want %b", n, sb_err, m_err); bad++;
            end else passes++;
            tick();
        end
        $display("random: 500 cycles, %0d mismatching comparisons", bad);
    endtask

    initial begin
        idle();
        for (int r = 0; r < REG_NUM; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
        test_reset();
        test_write_through();
        test_collision();
        test_saturation();
        test_multi_retire();
        test_underflow();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
